// File: rtl/vec_mem_pkg.sv
// Shared types and sizing for the vector <-> memory serializer.
// The top and the packer import this package so they agree on the lane geometry
// and on the FSM state encoding.
package vec_mem_pkg;

  // Default geometry: eight 32-bit memory words make up one 256-bit vector register.
  localparam int VEC_N      = 256;
  localparam int W          = 32;
  localparam int LANES      = VEC_N / W;
  localparam int LANE_IDX_W = $clog2(LANES);

  // Sequencer states. A load runs LOAD -> LOAD_DRAIN -> WRITEBACK.
  // A store runs STORE -> DONE.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_DRAIN,
    WRITEBACK,
    STORE,
    DONE
  } vmem_state_t;

endpackage

// File: rtl/vec_word_packer.sv
// Packs memory words into a full vector register image, one lane at a time.
// Lane i occupies bits [WORD_W*i +: WORD_W]. A clear wipes the whole buffer so that
// a new load can never expose lanes left over from an earlier or aborted one.
module vec_word_packer
  import vec_mem_pkg::*;
#(
  parameter int WORD_W    = W,
  parameter int NUM_LANES = LANES,
  parameter int IDX_W     = LANE_IDX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        capture,
  input  logic [IDX_W-1:0]            lane_idx,
  input  logic [WORD_W-1:0]           word_in,
  output logic [WORD_W*NUM_LANES-1:0] vec
);

  // Lane buffer: clear has priority over capture; capture writes only the selected lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec <= '0;
    end else if (clear) begin
      vec <= '0;
    end else if (capture) begin
      vec[WORD_W*int'(lane_idx) +: WORD_W] <= word_in;
    end
  end

endmodule

// File: rtl/vector_mem_serializer.sv
// Bridges the 32-bit data memory and the 256-bit vector register file.
// A vector load issues one read per lane, packs the returned words and then writes the
// vector register in a single VWE3 pulse. A vector store latches the whole register
// and emits one memory write per lane. busy is high for the whole operation so the
// pipeline can stall behind it.
module vector_mem_serializer #(
  parameter int N      = 256,
  parameter int W      = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        vreg_addr,
  input  logic [N-1:0]      store_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [W-1:0]      mem_rdata,
  output logic              mem_we,
  output logic [W-1:0]      mem_wdata,
  output logic [4:0]        VA3,
  output logic [N-1:0]      VWD3,
  output logic              VWE3,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import vec_mem_pkg::*;

  localparam int               NUM_LANES = N / W;
  localparam int               IDX_W     = $clog2(NUM_LANES);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_LANES - 1);

  vmem_state_t       state;
  logic [IDX_W-1:0]  lane_cnt;
  logic [IDX_W-1:0]  next_lane;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_pending;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] aligned_base;
  logic [ADDR_W-1:0] next_addr;
  logic [4:0]        vreg_q;
  logic [N-1:0]      store_q;
  logic [W-1:0]      next_store_word;
  logic [N-1:0]      packed_vec;
  logic [N-1:0]      merged_vec;
  logic              pack_clear;

  // Memory accesses are always word aligned, so the two low address bits are dropped.
  assign aligned_base = base_addr & ~ADDR_W'(3);

  // The lane counter is only IDX_W bits wide, so it wraps back to zero on the last lane.
  assign next_lane = lane_cnt + 1'b1;

  // Byte address of the next lane; the add is modulo 2^ADDR_W so high bases wrap to zero.
  assign next_addr = base_q + {{(ADDR_W-IDX_W-2){1'b0}}, next_lane, 2'b00};

  // Store word for the next lane, taken from the vector latched when the store was accepted.
  assign next_store_word = store_q[W*int'(next_lane) +: W];

  // The pack buffer is wiped whenever a valid load is accepted, so every load starts clean.
  assign pack_clear = (state == IDLE) && start_load && vreg_addr[4];

  // Final vector image: the buffer with the last returned word folded in, so the
  // register write can happen the cycle right after that word arrives.
  always_comb begin
    merged_vec = packed_vec;
    merged_vec[W*int'(rd_idx) +: W] = mem_rdata;
  end

  // Read-return tracking: a read issued this cycle returns data next cycle, so remember
  // that a read is outstanding and which lane it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending <= 1'b0;
      rd_idx     <= '0;
    end else begin
      rd_pending <= mem_rd_en;
      rd_idx     <= lane_cnt;
    end
  end

  vec_word_packer #(
    .WORD_W   (W),
    .NUM_LANES(NUM_LANES),
    .IDX_W    (IDX_W)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (pack_clear),
    .capture (rd_pending),
    .lane_idx(rd_idx),
    .word_in (mem_rdata),
    .vec     (packed_vec)
  );

  // Sequencer with registered outputs: accepts a request in IDLE, walks the lanes and
  // produces the memory strobes, the register writeback and the completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lane_cnt  <= '0;
      base_q    <= '0;
      vreg_q    <= '0;
      store_q   <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      VA3       <= '0;
      VWD3      <= '0;
      VWE3      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      VWE3 <= 1'b0;
      case (state)
        IDLE: begin
          mem_rd_en <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          busy      <= 1'b0;
          lane_cnt  <= '0;
          if (start_load) begin
            if (vreg_addr[4]) begin
              state     <= LOAD;
              busy      <= 1'b1;
              base_q    <= aligned_base;
              vreg_q    <= vreg_addr;
              mem_rd_en <= 1'b1;
              mem_addr  <= aligned_base;
            end else begin
              err <= 1'b1;
            end
          end else if (start_store) begin
            state     <= STORE;
            busy      <= 1'b1;
            base_q    <= aligned_base;
            store_q   <= store_data;
            mem_we    <= 1'b1;
            mem_addr  <= aligned_base;
            mem_wdata <= store_data[W-1:0];
          end
        end

        LOAD: begin
          lane_cnt <= next_lane;
          if (lane_cnt == LAST_LANE) begin
            state     <= LOAD_DRAIN;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
          end else begin
            mem_addr <= next_addr;
          end
        end

        LOAD_DRAIN: begin
          state <= WRITEBACK;
          VWE3  <= 1'b1;
          VA3   <= vreg_q;
          VWD3  <= merged_vec;
          done  <= 1'b1;
        end

        WRITEBACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        STORE: begin
          lane_cnt <= next_lane;
          if (lane_cnt == LAST_LANE) begin
            state     <= DONE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b1;
          end else begin
            mem_addr  <= next_addr;
            mem_wdata <= next_store_word;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_rd_en <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule
